// File: rtl/microsequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | microsequencer: registered next-state sequencer for the ARM control unit |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module microsequencer #(
  parameter int STATE_W     = 10,
  parameter int STACK_DEPTH = 4,
  parameter int MOC_TIMEOUT = 64,
  parameter int RESET_STATE = 0,
  parameter int FETCH_STATE = 1,
  parameter int FAULT_STATE = 1023
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               stall,
  input  logic [2:0]                         ns_sel,
  input  logic [STATE_W-1:0]                 ns_target,
  input  logic [STATE_W-1:0]                 dispatch_addr,
  input  logic                               dispatch_valid,
  input  logic                               Cond,
  input  logic                               MOC,
  output logic [STATE_W-1:0]                 state,
  output logic                               fault,
  output logic                               illegal_instr,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level
);

  localparam int SL_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int CNT_W = (MOC_TIMEOUT > 1) ? $clog2(MOC_TIMEOUT) : 1;

  localparam logic [2:0] c_SEQ      = 3'd0;
  localparam logic [2:0] c_JUMP     = 3'd1;
  localparam logic [2:0] c_DISPATCH = 3'd2;
  localparam logic [2:0] c_WAIT_MOC = 3'd3;
  localparam logic [2:0] c_COND     = 3'd4;
  localparam logic [2:0] c_CALL     = 3'd5;
  localparam logic [2:0] c_RET      = 3'd6;

  localparam logic [STATE_W-1:0] c_RESET_ST = STATE_W'(RESET_STATE);
  localparam logic [STATE_W-1:0] c_FETCH_ST = STATE_W'(FETCH_STATE);
  localparam logic [STATE_W-1:0] c_FAULT_ST = STATE_W'(FAULT_STATE);
  localparam logic [SL_W-1:0]    c_DEPTH    = SL_W'(STACK_DEPTH);
  localparam logic [CNT_W-1:0]   c_CNT_LAST = CNT_W'((MOC_TIMEOUT > 0) ? MOC_TIMEOUT - 1 : 0);
  localparam bit                 c_TO_EN    = (MOC_TIMEOUT != 0);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next;
  logic [STATE_W-1:0] w_incr;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [SL_W-1:0]    r_level;
  logic [SL_W-1:0]    w_level_next;
  logic               r_fault;
  logic               w_fault_set;
  logic               r_illegal;
  logic               w_illegal;
  logic               w_push;
  logic               w_full;
  logic               w_empty;
  logic [IDX_W-1:0]   w_push_idx;
  logic [IDX_W-1:0]   w_pop_idx;
  logic [STATE_W-1:0] r_stack [STACK_DEPTH];

  assign w_incr     = r_state + 1'b1;
  assign w_full     = (r_level == c_DEPTH);
  assign w_empty    = (r_level == '0);
  assign w_push_idx = IDX_W'(r_level);
  assign w_pop_idx  = IDX_W'(r_level - 1'b1);

  always_comb begin
    w_next       = w_incr;
    w_cnt_next   = '0;
    w_level_next = r_level;
    w_push       = 1'b0;
    w_fault_set  = 1'b0;
    w_illegal    = 1'b0;
    case (ns_sel)
      c_SEQ: begin
        w_next = w_incr;
      end
      c_JUMP: begin
        w_next = ns_target;
      end
      c_DISPATCH: begin
        if (dispatch_valid) begin
          w_next = dispatch_addr;
        end else begin
          w_next    = c_FETCH_ST;
          w_illegal = 1'b1;
        end
      end
      c_WAIT_MOC: begin
        // The counter holds the number of MOC=0 cycles already spent here.
        if (MOC) begin
          w_next = w_incr;
        end else if (c_TO_EN && (r_cnt == c_CNT_LAST)) begin
          w_next      = c_FAULT_ST;
          w_fault_set = 1'b1;
        end else begin
          w_next     = r_state;
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      c_COND: begin
        w_next = Cond ? ns_target : c_FETCH_ST;
      end
      c_CALL: begin
        if (w_full) begin
          w_next      = c_FAULT_ST;
          w_fault_set = 1'b1;
        end else begin
          w_next       = ns_target;
          w_push       = 1'b1;
          w_level_next = r_level + 1'b1;
        end
      end
      c_RET: begin
        if (w_empty) begin
          w_next      = c_FAULT_ST;
          w_fault_set = 1'b1;
        end else begin
          w_next       = r_stack[w_pop_idx];
          w_level_next = r_level - 1'b1;
        end
      end
      default: begin
        w_next = c_FETCH_ST;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= c_RESET_ST;
      r_cnt     <= '0;
      r_level   <= '0;
      r_fault   <= 1'b0;
      r_illegal <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        r_stack[i] <= '0;
      end
    end else if (!stall) begin
      r_state   <= w_next;
      r_cnt     <= w_cnt_next;
      r_level   <= w_level_next;
      r_fault   <= r_fault | w_fault_set;
      r_illegal <= w_illegal;
      if (w_push) begin
        r_stack[w_push_idx] <= w_incr;
      end
    end
  end

  assign state         = r_state;
  assign fault         = r_fault;
  assign illegal_instr = r_illegal;
  assign stack_level   = r_level;

endmodule
`default_nettype wire

// File: tb/tb_microsequencer.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for microsequencer: two instances (MOC timeout 8 and 4, stack depth 2)
// share stimulus; a spec model fills a scoreboard checked after every edge.
module tb_microsequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       stall = 1'b0;
  logic [2:0] ns_sel = 3'd0;
  logic [9:0] ns_target = '0;
  logic [9:0] dispatch_addr = '0;
  logic       dispatch_valid = 1'b0;
  logic       Cond = 1'b0;
  logic       MOC = 1'b0;

  logic [9:0] state_a, state_b;
  logic       fault_a, fault_b, ill_a, ill_b;
  logic [1:0] lvl_a, lvl_b;

  microsequencer #(.STATE_W(10), .STACK_DEPTH(2), .MOC_TIMEOUT(8),
                   .RESET_STATE(0), .FETCH_STATE(1), .FAULT_STATE(1023)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .stall(stall), .ns_sel(ns_sel),
    .ns_target(ns_target), .dispatch_addr(dispatch_addr),
    .dispatch_valid(dispatch_valid), .Cond(Cond), .MOC(MOC),
    .state(state_a), .fault(fault_a), .illegal_instr(ill_a), .stack_level(lvl_a)
  );

  microsequencer #(.STATE_W(10), .STACK_DEPTH(2), .MOC_TIMEOUT(4),
                   .RESET_STATE(0), .FETCH_STATE(1), .FAULT_STATE(1023)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .stall(stall), .ns_sel(ns_sel),
    .ns_target(ns_target), .dispatch_addr(dispatch_addr),
    .dispatch_valid(dispatch_valid), .Cond(Cond), .MOC(MOC),
    .state(state_b), .fault(fault_b), .illegal_instr(ill_b), .stack_level(lvl_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] st;
    logic       flt;
    logic       ill;
    logic [1:0] lvl;
  } obs_t;

  obs_t sb_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  int   m_st[2];
  int   m_cnt[2];
  int   m_lvl[2];
  bit   m_flt[2];
  bit   m_ill[2];
  int   m_stk[2][2];
  int   c_to[2] = '{8, 4};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_cnt[i] = 0; m_lvl[i] = 0; m_flt[i] = 0; m_ill[i] = 0;
    end
  endtask

  task automatic model_step();
    if (stall) return;
    for (int i = 0; i < 2; i++) begin
      int nx;
      int cnt;
      bit ill;
      nx = (m_st[i] + 1) % 1024;
      cnt = 0;
      ill = 0;
      case (ns_sel)
        3'd1: nx = int'(ns_target);
        3'd2: if (dispatch_valid) nx = int'(dispatch_addr); else begin nx = 1; ill = 1; end
        3'd3: if (!MOC) begin
                if (c_to[i] != 0 && m_cnt[i] == c_to[i] - 1) begin nx = 1023; m_flt[i] = 1; end
                else begin nx = m_st[i]; cnt = m_cnt[i] + 1; end
              end
        3'd4: nx = Cond ? int'(ns_target) : 1;
        3'd5: if (m_lvl[i] == 2) begin nx = 1023; m_flt[i] = 1; end
              else begin
                m_stk[i][m_lvl[i]] = (m_st[i] + 1) % 1024;
                m_lvl[i]++;
                nx = int'(ns_target);
              end
        3'd6: if (m_lvl[i] == 0) begin nx = 1023; m_flt[i] = 1; end
              else begin m_lvl[i]--; nx = m_stk[i][m_lvl[i]]; end
        3'd7: nx = 1;
        default: ;
      endcase
      m_st[i] = nx;
      m_cnt[i] = cnt;
      m_ill[i] = ill;
    end
  endtask

  // Drives inputs for one edge, predicts, then compares just after the edge.
  task automatic go(input logic [2:0] sel, input logic [9:0] tgt, input logic c,
                    input logic m, input logic dv, input logic [9:0] da, input logic st);
    obs_t e;
    ns_sel = sel; ns_target = tgt; Cond = c; MOC = m;
    dispatch_valid = dv; dispatch_addr = da; stall = st;
    model_step();
    for (int i = 0; i < 2; i++) begin
      e.st = 10'(m_st[i]); e.flt = m_flt[i]; e.ill = m_ill[i]; e.lvl = 2'(m_lvl[i]);
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("a_state", 32'(state_a), 32'(e.st));
    chk("a_fault", 32'(fault_a), 32'(e.flt));
    chk("a_illegal", 32'(ill_a), 32'(e.ill));
    chk("a_level", 32'(lvl_a), 32'(e.lvl));
    e = sb_q.pop_front();
    chk("b_state", 32'(state_b), 32'(e.st));
    chk("b_fault", 32'(fault_b), 32'(e.flt));
    chk("b_illegal", 32'(ill_b), 32'(e.ill));
    chk("b_level", 32'(lvl_b), 32'(e.lvl));
  endtask

  task automatic seq_n(input int n);
    for (int k = 0; k < n; k++) go(3'd0, '0, 0, 0, 0, '0, 0);
  endtask

  // Asserts reset between edges and checks outputs before any clock edge.
  task automatic do_reset();
    reset_n = 1'b0;
    stall = 1'b0;
    #1;
    model_reset();
    sb_q.delete();
    chk("rst_async_state_a", 32'(state_a), 0);
    chk("rst_async_state_b", 32'(state_b), 0);
    chk("rst_fault_a", 32'(fault_a), 0);
    chk("rst_level_b", 32'(lvl_b), 0);
    chk("rst_illegal_a", 32'(ill_a), 0);
    @(posedge clk);
    #1;
    chk("rst_hold_state_a", 32'(state_a), 0);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    do_reset();
    go(3'd1, 10'd37, 0, 0, 0, '0, 0);
    chk("pre_reset_state", 32'(state_a), 37);
    do_reset();
    seq_n(3);
    chk("seq_state", 32'(state_a), 3);

    for (int k = 0; k < 5; k++) go(3'd3, '0, 0, 0, 0, '0, 0);
    chk("moc_wait_hold", 32'(state_a), 3);
    go(3'd3, '0, 0, 1, 0, '0, 0);
    chk("moc_done_state", 32'(state_a), 4);
    chk("moc_done_fault", 32'(fault_a), 0);

    do_reset();
    seq_n(3);
    for (int k = 0; k < 7; k++) go(3'd3, '0, 0, 0, 0, '0, 0);
    chk("timeout_pre_state", 32'(state_a), 3);
    chk("timeout_pre_fault", 32'(fault_a), 0);
    go(3'd3, '0, 0, 0, 0, '0, 0);
    chk("timeout_state", 32'(state_a), 1023);
    chk("timeout_fault", 32'(fault_a), 1);
    seq_n(2);
    chk("fault_sticky", 32'(fault_a), 1);

    go(3'd2, '0, 0, 0, 1, 10'd203, 0);
    chk("dispatch_ok", 32'(state_a), 203);
    go(3'd2, '0, 0, 0, 0, 10'd77, 0);
    chk("dispatch_bad_state", 32'(state_a), 1);
    chk("dispatch_bad_pulse", 32'(ill_a), 1);
    seq_n(1);
    chk("dispatch_pulse_end", 32'(ill_a), 0);

    do_reset();
    go(3'd1, 10'd10, 0, 0, 0, '0, 0);
    go(3'd5, 10'd100, 0, 0, 0, '0, 0);
    go(3'd5, 10'd200, 0, 0, 0, '0, 0);
    chk("call2_level", 32'(lvl_a), 2);
    go(3'd5, 10'd300, 0, 0, 0, '0, 0);
    chk("call_full_state", 32'(state_a), 1023);
    chk("call_full_level", 32'(lvl_a), 2);
    go(3'd6, '0, 0, 0, 0, '0, 0);
    chk("ret1_state", 32'(state_a), 101);
    go(3'd6, '0, 0, 0, 0, '0, 0);
    chk("ret2_state", 32'(state_a), 11);
    chk("ret2_level", 32'(lvl_a), 0);
    go(3'd6, '0, 0, 0, 0, '0, 0);
    chk("ret_empty_state", 32'(state_a), 1023);
    go(3'd1, 10'd20, 0, 0, 0, '0, 0);
    go(3'd5, 10'd40, 0, 0, 0, '0, 0);
    go(3'd6, '0, 0, 0, 0, '0, 0);
    chk("call_ret_state", 32'(state_a), 21);

    go(3'd4, 10'd50, 1, 0, 0, '0, 0);
    chk("cond_true", 32'(state_a), 50);
    go(3'd4, 10'd50, 0, 0, 0, '0, 0);
    chk("cond_false", 32'(state_a), 1);
    go(3'd7, '0, 0, 0, 0, '0, 0);

    do_reset();
    seq_n(5);
    go(3'd3, '0, 0, 0, 0, '0, 0);
    go(3'd3, '0, 0, 0, 0, '0, 0);
    for (int k = 0; k < 3; k++) begin
      go(3'd3, '0, 0, 1, 0, '0, 1);
      chk("stall_hold_b", 32'(state_b), 5);
    end
    go(3'd3, '0, 0, 0, 0, '0, 0);
    chk("stall_no_to_b", 32'(fault_b), 0);
    go(3'd3, '0, 0, 0, 0, '0, 0);
    chk("stall_to_b", 32'(state_b), 1023);

    do_reset();
    for (int k = 0; k < 400; k++) begin
      go(3'($urandom_range(0, 7)), 10'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
         1'($urandom), 10'($urandom), 1'($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
